// File: rtl/imem_loader.sv
// Instruction-memory loader: takes 32-bit words over a valid/ready stream and writes
// them big-endian, one byte per cycle, into the byte-wide instruction store.
module imem_loader #(
    parameter int DEPTH = 100
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        start,
    input  logic [31:0] start_addr,
    input  logic [7:0]  num_words,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    output logic        in_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [7:0]  mem_byte,
    output logic        cpu_hold,
    output logic        done,
    output logic        err,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_WORD = 2'd1,
        WRITE     = 2'd2,
        DONE      = 2'd3
    } state_t;

    localparam logic [32:0] LAST_ADDR = 33'(DEPTH - 1);

    state_t      state, state_n;
    logic [31:0] addr_cnt, addr_n;
    logic [7:0]  rem, rem_n;
    logic [31:0] word, word_n;
    logic [1:0]  k, k_n;
    logic        we_n, err_n;
    logic [31:0] maddr_n;
    logic [7:0]  mbyte_n;
    logic [32:0] end_addr;
    logic [1:0]  k_inc;

    // Handshake: a word transfers on a rising edge where in_valid && in_ready.
    // in_ready is a registered decode of WAIT_WORD, so it never depends on in_valid.

    // 33-bit sum so an address near 2^32 cannot wrap back into range.
    assign end_addr  = {1'b0, addr_cnt} + 33'd3;
    assign k_inc     = k + 2'd1;
    assign dbg_state = state;

    function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] idx);
        case (idx)
            2'd0:    byte_of = w[31:24];
            2'd1:    byte_of = w[23:16];
            2'd2:    byte_of = w[15:8];
            default: byte_of = w[7:0];
        endcase
    endfunction

    always_comb begin
        state_n = state;
        addr_n  = addr_cnt;
        rem_n   = rem;
        word_n  = word;
        k_n     = k;
        we_n    = 1'b0;
        maddr_n = mem_addr;
        mbyte_n = mem_byte;
        err_n   = err;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    addr_n = start_addr;
                    rem_n  = num_words;
                    err_n  = 1'b0;
                    if (start_addr[1:0] != 2'd0) begin
                        state_n = DONE;
                        err_n   = 1'b1;
                    end else if (num_words == 8'd0) begin
                        state_n = DONE;
                    end else begin
                        state_n = WAIT_WORD;
                    end
                end
            end
            WAIT_WORD: begin
                if (in_valid && in_ready) begin
                    if (end_addr > LAST_ADDR) begin
                        state_n = DONE;
                        err_n   = 1'b1;
                    end else begin
                        state_n = WRITE;
                        word_n  = in_data;
                        k_n     = 2'd0;
                        we_n    = 1'b1;
                        maddr_n = addr_cnt;
                        mbyte_n = in_data[31:24];
                    end
                end
            end
            WRITE: begin
                if (k == 2'd3) begin
                    addr_n  = addr_cnt + 32'd4;
                    rem_n   = rem - 8'd1;
                    state_n = (rem == 8'd1) ? DONE : WAIT_WORD;
                end else begin
                    k_n     = k_inc;
                    we_n    = 1'b1;
                    maddr_n = addr_cnt + {30'd0, k_inc};
                    mbyte_n = byte_of(word, k_inc);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Outputs are registered from the next-state decode so they line up with the state.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state    <= IDLE;
            addr_cnt <= 32'd0;
            rem      <= 8'd0;
            word     <= 32'd0;
            k        <= 2'd0;
            in_ready <= 1'b0;
            mem_we   <= 1'b0;
            mem_addr <= 32'd0;
            mem_byte <= 8'd0;
            cpu_hold <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_n;
            addr_cnt <= addr_n;
            rem      <= rem_n;
            word     <= word_n;
            k        <= k_n;
            in_ready <= (state_n == WAIT_WORD);
            mem_we   <= we_n;
            mem_addr <= maddr_n;
            mem_byte <= mbyte_n;
            cpu_hold <= (state_n == WAIT_WORD) || (state_n == WRITE);
            done     <= (state_n == DONE);
            err      <= err_n;
        end
    end

endmodule
